// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: it produces the program counter load enable and value,
// the instruction fetch request and the IF/ID flush. It handles the boot delay,
// sequential advance, redirects (debug, trap, dret, mret, branch), WFI sleep
// and debug mode.
//
// state | meaning
// BOOT  | idle after reset; counts up to BOOT_DELAY, then loads BOOT_ADDR
// RUN   | normal fetch; sequential advance or redirect
// WFI   | sleeping; no fetch; woken by trap, debug request or wake_i
// DEBUG | fetching from the debug ROM; fetches like RUN
module fetch_pc_sequencer #(
    parameter logic [31:0] BOOT_ADDR  = 32'hFFFFF000,
    parameter logic [31:0] DEBUG_ADDR = 32'h00000800,
    parameter int unsigned BOOT_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc_i,
    input  logic        stall_i,
    input  logic        fetch_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        trap_i,
    input  logic [31:0] trap_vector_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    input  logic        debug_req_i,
    input  logic        dret_i,
    input  logic        wfi_i,
    input  logic        wake_i,
    output logic        pc_en_o,
    output logic [31:0] next_pc_o,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    output logic        flush_o,
    output logic        debug_mode_o,
    output logic [31:0] dpc_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WFI   = 2'd2,
        ST_DEBUG = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_DELAY_C = 8'(BOOT_DELAY);

    state_t      state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        redirect;

    // Incrementing by 4 in 32 bits wraps 32'hFFFFFFFC to zero.
    assign seq_pc = current_pc_i + 32'd4;

    // State, boot counter and saved debug PC registers, with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 8'd0;
            dpc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            dpc_q      <= dpc_d;
        end
    end

    // Next state, redirect selection and per-state fetch/PC control
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        dpc_d       = dpc_q;
        target      = seq_pc;
        redirect    = 1'b0;
        pc_en_o     = 1'b0;
        fetch_req_o = 1'b0;

        case (state_q)
            ST_BOOT: begin
                target = BOOT_ADDR;
                if (boot_cnt_q == BOOT_DELAY_C) begin
                    pc_en_o    = 1'b1;
                    boot_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end

            ST_RUN: begin
                fetch_req_o = 1'b1;
                if (debug_req_i) begin
                    // A branch resolving in the same cycle is where execution resumes.
                    redirect = 1'b1;
                    target   = DEBUG_ADDR;
                    dpc_d    = branch_taken_i ? branch_target_i : current_pc_i;
                    state_d  = ST_DEBUG;
                end else if (trap_i) begin
                    redirect = 1'b1;
                    target   = trap_vector_i;
                end else if (mret_i) begin
                    redirect = 1'b1;
                    target   = mepc_i;
                end else if (branch_taken_i) begin
                    redirect = 1'b1;
                    target   = branch_target_i;
                end else begin
                    pc_en_o = fetch_ready_i & ~stall_i;
                    if (wfi_i) begin
                        state_d = ST_WFI;
                    end
                end
            end

            ST_WFI: begin
                if (debug_req_i) begin
                    redirect = 1'b1;
                    target   = DEBUG_ADDR;
                    dpc_d    = current_pc_i;
                    state_d  = ST_DEBUG;
                end else if (trap_i) begin
                    redirect = 1'b1;
                    target   = trap_vector_i;
                    state_d  = ST_RUN;
                end else if (wake_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_DEBUG: begin
                fetch_req_o = 1'b1;
                // A trap inside the debug ROM re-enters the debug ROM entry point.
                if (trap_i) begin
                    redirect = 1'b1;
                    target   = DEBUG_ADDR;
                end else if (dret_i) begin
                    redirect = 1'b1;
                    target   = dpc_q;
                    state_d  = ST_RUN;
                end else if (branch_taken_i) begin
                    redirect = 1'b1;
                    target   = branch_target_i;
                end else begin
                    pc_en_o = fetch_ready_i & ~stall_i;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (redirect) begin
            pc_en_o = 1'b1;
        end
    end

    assign flush_o      = redirect;
    assign next_pc_o    = target & ~32'h3;
    assign fetch_addr_o = current_pc_i;
    assign debug_mode_o = (state_q == ST_DEBUG);
    assign dpc_o        = dpc_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Testbench for fetch_pc_sequencer. It applies a table of per-cycle vectors
// through a scoreboard queue and then runs a hand-written boot-latency sequence.
module tb_fetch_pc_sequencer;

    localparam logic [31:0] BOOT_A  = 32'hFFFFF000;
    localparam logic [31:0] DEBUG_A = 32'h00000800;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc_i;
    logic        stall_i, fetch_ready_i, branch_taken_i, trap_i, mret_i;
    logic [31:0] branch_target_i, trap_vector_i, mepc_i;
    logic        debug_req_i, dret_i, wfi_i, wake_i;
    logic        pc_en_o, fetch_req_o, flush_o, debug_mode_o;
    logic [31:0] next_pc_o, fetch_addr_o, dpc_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_pc_sequencer #(
        .BOOT_ADDR (BOOT_A),
        .DEBUG_ADDR(DEBUG_A),
        .BOOT_DELAY(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc_i   (current_pc_i),
        .stall_i        (stall_i),
        .fetch_ready_i  (fetch_ready_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .trap_i         (trap_i),
        .trap_vector_i  (trap_vector_i),
        .mret_i         (mret_i),
        .mepc_i         (mepc_i),
        .debug_req_i    (debug_req_i),
        .dret_i         (dret_i),
        .wfi_i          (wfi_i),
        .wake_i         (wake_i),
        .pc_en_o        (pc_en_o),
        .next_pc_o      (next_pc_o),
        .fetch_req_o    (fetch_req_o),
        .fetch_addr_o   (fetch_addr_o),
        .flush_o        (flush_o),
        .debug_mode_o   (debug_mode_o),
        .dpc_o          (dpc_o)
    );

    typedef struct packed {
        logic        rst;
        logic [31:0] pc;
        logic        stall, rdy, br;
        logic [31:0] bt;
        logic        trap;
        logic [31:0] tv;
        logic        mret;
        logic [31:0] mepc;
        logic        dreq, dret, wfi, wake;
        logic        e_pc_en;
        logic        chk_npc;
        logic [31:0] e_npc;
        logic        e_freq;
        logic        e_flush;
        logic        e_dmode;
        logic [31:0] e_dpc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Quiet cycle: no redirect, fetch not ready, so no PC load is expected.
    function automatic vec_t mk(input logic [31:0] pc, input logic dm, input logic [31:0] dp);
        vec_t v;
        v = '0;
        v.pc      = pc;
        v.e_freq  = 1'b1;
        v.e_dmode = dm;
        v.e_dpc   = dp;
        return v;
    endfunction

    function automatic vec_t adv(input logic [31:0] pc, input logic [31:0] npc,
                                 input logic dm, input logic [31:0] dp);
        vec_t v;
        v = mk(pc, dm, dp);
        v.rdy     = 1'b1;
        v.e_pc_en = 1'b1;
        v.chk_npc = 1'b1;
        v.e_npc   = npc;
        return v;
    endfunction

    function automatic vec_t rd(input logic [31:0] pc, input logic [31:0] npc,
                                input logic dm, input logic [31:0] dp);
        vec_t v;
        v = adv(pc, npc, dm, dp);
        v.rdy     = 1'b0;
        v.e_flush = 1'b1;
        return v;
    endfunction

    function automatic vec_t boot_v();
        vec_t v;
        v = mk(32'h0000_1234, 1'b0, 32'd0);
        v.rdy     = 1'b1;
        v.e_freq  = 1'b0;
        v.chk_npc = 1'b1;
        v.e_npc   = BOOT_A;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        reset           = v.rst;
        current_pc_i    = v.pc;
        stall_i         = v.stall;
        fetch_ready_i   = v.rdy;
        branch_taken_i  = v.br;
        branch_target_i = v.bt;
        trap_i          = v.trap;
        trap_vector_i   = v.tv;
        mret_i          = v.mret;
        mepc_i          = v.mepc;
        debug_req_i     = v.dreq;
        dret_i          = v.dret;
        wfi_i           = v.wfi;
        wake_i          = v.wake;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("v%0d pc_en", idx), 32'(pc_en_o), 32'(e.e_pc_en));
        chk($sformatf("v%0d fetch_req", idx), 32'(fetch_req_o), 32'(e.e_freq));
        chk($sformatf("v%0d flush", idx), 32'(flush_o), 32'(e.e_flush));
        chk($sformatf("v%0d fetch_addr", idx), fetch_addr_o, e.pc);
        chk($sformatf("v%0d debug_mode", idx), 32'(debug_mode_o), 32'(e.e_dmode));
        chk($sformatf("v%0d dpc", idx), dpc_o, e.e_dpc);
        if (e.chk_npc) chk($sformatf("v%0d next_pc", idx), next_pc_o, e.e_npc);
    endtask

    initial begin
        vec_t v;
        int   n, early;
        logic found;

        // Boot after reset release: four idle cycles, then the BOOT_ADDR load.
        for (int i = 0; i < 4; i++) tbl.push_back(boot_v());
        v = boot_v(); v.e_pc_en = 1'b1; tbl.push_back(v);
        // Sequential advance, stall/not-ready hold, and wrap at the top of memory.
        tbl.push_back(adv(BOOT_A, 32'hFFFFF004, 0, 0));
        tbl.push_back(adv(32'h100, 32'h104, 0, 0));
        v = mk(32'h100, 0, 0); v.stall = 1; v.rdy = 1; tbl.push_back(v);
        tbl.push_back(mk(32'h100, 0, 0));
        tbl.push_back(adv(32'hFFFFFFFC, 32'h0, 0, 0));
        // Trap beats branch under stall; the flush lasts one cycle only.
        v = rd(32'h100, 32'h80, 0, 0); v.stall = 1; v.br = 1; v.bt = 32'h200;
        v.trap = 1; v.tv = 32'h80; tbl.push_back(v);
        v = mk(32'h80, 0, 0); v.stall = 1; v.rdy = 1; tbl.push_back(v);
        // mret beats branch; redirect targets have bits [1:0] cleared.
        v = rd(32'h100, 32'h120, 0, 0); v.mret = 1; v.mepc = 32'h123; v.br = 1;
        v.bt = 32'h200; tbl.push_back(v);
        v = rd(32'h120, 32'h204, 0, 0); v.br = 1; v.bt = 32'h206; v.rdy = 1;
        v.stall = 1; tbl.push_back(v);
        // Debug entry beats trap; DEBUG ignores mret, debug_req and wfi.
        v = rd(32'h300, DEBUG_A, 0, 0); v.dreq = 1; v.trap = 1; v.tv = 32'h80; tbl.push_back(v);
        tbl.push_back(adv(32'h800, 32'h804, 1, 32'h300));
        v = mk(32'h804, 1, 32'h300); v.mret = 1; v.mepc = 32'h500; v.dreq = 1;
        v.wfi = 1; tbl.push_back(v);
        v = rd(32'h804, DEBUG_A, 1, 32'h300); v.trap = 1; v.tv = 32'h40; tbl.push_back(v);
        v = rd(32'h800, 32'h300, 1, 32'h300); v.dret = 1; v.br = 1; v.bt = 32'h900; tbl.push_back(v);
        tbl.push_back(adv(32'h300, 32'h304, 0, 32'h300));
        // Debug entry alongside a taken branch saves the branch target.
        v = rd(32'h304, DEBUG_A, 0, 32'h300); v.dreq = 1; v.br = 1; v.bt = 32'h40A; tbl.push_back(v);
        tbl.push_back(mk(32'h800, 1, 32'h40A));
        v = rd(32'h800, 32'h408, 1, 32'h40A); v.dret = 1; tbl.push_back(v);
        // WFI: no fetch, unrelated inputs ignored, trap wakes to RUN.
        v = mk(32'h408, 0, 32'h40A); v.wfi = 1; tbl.push_back(v);
        v = mk(32'h408, 0, 32'h40A); v.e_freq = 0; v.rdy = 1; v.br = 1; v.bt = 32'h200;
        v.mret = 1; v.mepc = 32'h500; v.dret = 1; tbl.push_back(v);
        v = rd(32'h408, 32'h40, 0, 32'h40A); v.e_freq = 0; v.trap = 1; v.tv = 32'h40;
        v.rdy = 1; tbl.push_back(v);
        tbl.push_back(adv(32'h40, 32'h44, 0, 32'h40A));
        // WFI woken by wake_i without a PC change.
        v = mk(32'h44, 0, 32'h40A); v.wfi = 1; tbl.push_back(v);
        v = mk(32'h44, 0, 32'h40A); v.e_freq = 0; v.wake = 1; tbl.push_back(v);
        tbl.push_back(mk(32'h44, 0, 32'h40A));
        // WFI debug request beats trap and saves the sleeping PC.
        v = mk(32'h44, 0, 32'h40A); v.wfi = 1; tbl.push_back(v);
        v = rd(32'h44, DEBUG_A, 0, 32'h40A); v.e_freq = 0; v.dreq = 1; v.trap = 1;
        v.tv = 32'h40; tbl.push_back(v);
        tbl.push_back(mk(32'h800, 1, 32'h44));
        // Reset in DEBUG, then the boot sequence repeats.
        v = mk(32'h800, 1, 32'h44); v.rst = 1; tbl.push_back(v);
        for (int i = 0; i < 4; i++) tbl.push_back(boot_v());
        v = boot_v(); v.e_pc_en = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(BOOT_A, 0, 0));
        // Reset during a redirect cycle still lands in BOOT.
        v = rd(BOOT_A, 32'h80, 0, 0); v.trap = 1; v.tv = 32'h80; v.rst = 1; tbl.push_back(v);
        tbl.push_back(boot_v());

        reset = 1'b1;
        current_pc_i = '0; stall_i = 0; fetch_ready_i = 0; branch_taken_i = 0;
        branch_target_i = '0; trap_i = 0; trap_vector_i = '0; mret_i = 0; mepc_i = '0;
        debug_req_i = 0; dret_i = 0; wfi_i = 0; wake_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset fetch_req", 32'(fetch_req_o), 32'd0);
        chk("reset pc_en", 32'(pc_en_o), 32'd0);
        chk("reset next_pc", next_pc_o, BOOT_A);

        foreach (tbl[i]) apply(tbl[i], i);

        // Boot latency counted directly with a bounded wait for the first PC load.
        @(posedge clk); #1;
        reset = 1'b1; fetch_ready_i = 1'b1; current_pc_i = 32'h0000_5550;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0; early = 0; found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (pc_en_o) begin
                found = 1'b1;
                break;
            end
            if (fetch_req_o || flush_o) early++;
        end
        chk("boot load seen", 32'(found), 32'd1);
        chk("boot load cycle", 32'(n), 32'd5);
        chk("boot idle fetch/flush", 32'(early), 32'd0);
        chk("boot load addr", next_pc_o, BOOT_A);
        chk("boot load flush", 32'(flush_o), 32'd0);
        @(negedge clk);
        chk("run after boot fetch_req", 32'(fetch_req_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
